// File: rtl/j_result_collector.sv
// rtl/j_result_collector.sv - bit-serial row-result collector with round-robin drain
//
// Reassembles LSB-first serial words from 4*SUBARRAY_HEIGHT east-edge lanes into
// sign-extended parallel words, holds one finished word per lane, and drains the
// held words onto a single valid/ready stream.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   result         serial data bit per lane (lane n = row n/4, sub-lane n%4)
//   result_en      lane bit valid this cycle
//   result_start   first (LSB) bit of a word, qualified by result_en
//   result_end     last (sign) bit of a word, qualified by result_en
//   out_valid      output word valid
//   out_ready      consumer accepts when out_valid & out_ready
//   out_data       sign-extended word
//   out_lane       source lane index
//   out_len        serial bit count of the word (1..ACC_WIDTH)
//   err_overflow   sticky per lane: finished word dropped, holding register full
//   err_frame      sticky per lane: protocol violation
module j_result_collector #(
  parameter int SUBARRAY_HEIGHT = 1,
  parameter int ACC_WIDTH       = 16,
  localparam int NL             = 4 * SUBARRAY_HEIGHT,
  localparam int W_LANE         = (NL > 1) ? $clog2(NL) : 1,
  localparam int W_LEN          = $clog2(ACC_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NL-1:0]        result,
  input  logic [NL-1:0]        result_en,
  input  logic [NL-1:0]        result_start,
  input  logic [NL-1:0]        result_end,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic [W_LANE-1:0]    out_lane,
  output logic [W_LEN-1:0]     out_len,
  output logic [NL-1:0]        err_overflow,
  output logic [NL-1:0]        err_frame
);

  typedef enum logic {IDLE, ASSEMBLE} lane_state_e;

  localparam logic [W_LEN-1:0] MAX_CNT = W_LEN'(ACC_WIDTH);

  lane_state_e          state_q [NL];
  lane_state_e          state_d [NL];
  logic [W_LEN-1:0]     cnt_q [NL];
  logic [W_LEN-1:0]     cnt_d [NL];
  logic [ACC_WIDTH-1:0] asm_q [NL];
  logic [ACC_WIDTH-1:0] asm_d [NL];
  logic [ACC_WIDTH-1:0] hold_data_q [NL];
  logic [ACC_WIDTH-1:0] hold_data_d [NL];
  logic [W_LEN-1:0]     hold_len_q [NL];
  logic [W_LEN-1:0]     hold_len_d [NL];
  logic [NL-1:0]        hold_valid_q, hold_valid_d;
  logic [NL-1:0]        err_overflow_q, err_overflow_d;
  logic [NL-1:0]        err_frame_q, err_frame_d;

  logic                 out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0] out_data_q, out_data_d;
  logic [W_LANE-1:0]    out_lane_q, out_lane_d;
  logic [W_LEN-1:0]     out_len_q, out_len_d;
  logic [W_LANE-1:0]    ptr_q, ptr_d;

  // Per-lane completion strobes produced by the assemblers this cycle
  logic [NL-1:0]        done;
  logic [ACC_WIDTH-1:0] done_word [NL];
  logic [W_LEN-1:0]     done_len [NL];

  logic [NL-1:0]        grant;
  logic [W_LANE-1:0]    gnt_idx;
  logic                 found;

  // Serial assemblers
  always_comb begin
    err_frame_d = err_frame_q;
    for (int n = 0; n < NL; n++) begin
      state_d[n]   = state_q[n];
      cnt_d[n]     = cnt_q[n];
      asm_d[n]     = asm_q[n];
      done[n]      = 1'b0;
      done_word[n] = '0;
      done_len[n]  = '0;
      if (result_en[n]) begin
        if (result_start[n]) begin
          // A start while assembling abandons the partial word and restarts
          if (state_q[n] == ASSEMBLE) err_frame_d[n] = 1'b1;
          asm_d[n]    = '0;
          asm_d[n][0] = result[n];
          if (result_end[n]) begin
            done[n]      = 1'b1;
            done_word[n] = {ACC_WIDTH{result[n]}};
            done_len[n]  = W_LEN'(1);
            state_d[n]   = IDLE;
            cnt_d[n]     = '0;
          end else begin
            state_d[n] = ASSEMBLE;
            cnt_d[n]   = W_LEN'(1);
          end
        end else if (state_q[n] == IDLE) begin
          err_frame_d[n] = 1'b1;
        end else if (cnt_q[n] == MAX_CNT) begin
          // Word already full: extra bits are lost, bit ACC_WIDTH-1 stays the sign
          if (result_end[n]) begin
            done[n]      = 1'b1;
            done_word[n] = asm_q[n];
            done_len[n]  = MAX_CNT;
            state_d[n]   = IDLE;
            cnt_d[n]     = '0;
          end else begin
            err_frame_d[n] = 1'b1;
          end
        end else begin
          // Bits below cnt come from the assembler; this bit and above are the sign
          for (int i = 0; i < ACC_WIDTH; i++) begin
            if (i < int'(cnt_q[n])) done_word[n][i] = asm_q[n][i];
            else                    done_word[n][i] = result[n];
            if (i == int'(cnt_q[n])) asm_d[n][i] = result[n];
          end
          if (result_end[n]) begin
            done[n]     = 1'b1;
            done_len[n] = cnt_q[n] + 1'b1;
            state_d[n]  = IDLE;
            cnt_d[n]    = '0;
          end else begin
            cnt_d[n] = cnt_q[n] + 1'b1;
          end
        end
      end
    end
  end

  // Round-robin arbiter and output register
  always_comb begin
    int idx;
    idx         = 0;
    grant       = '0;
    gnt_idx     = '0;
    found       = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_lane_d  = out_lane_q;
    out_len_d   = out_len_q;
    ptr_d       = ptr_q;
    for (int k = 0; k < NL; k++) begin
      idx = (int'(ptr_q) + k) % NL;
      if (!found && hold_valid_q[idx]) begin
        found   = 1'b1;
        gnt_idx = W_LANE'(idx);
      end
    end
    if (!out_valid_q || out_ready) begin
      out_valid_d = found;
      if (found) begin
        grant[gnt_idx] = 1'b1;
        out_data_d     = hold_data_q[gnt_idx];
        out_lane_d     = gnt_idx;
        out_len_d      = hold_len_q[gnt_idx];
        if (int'(gnt_idx) == NL - 1) ptr_d = '0;
        else                         ptr_d = gnt_idx + 1'b1;
      end
    end
  end

  // Holding registers; a grant in the same cycle frees the slot for the new word
  always_comb begin
    err_overflow_d = err_overflow_q;
    hold_valid_d   = hold_valid_q & ~grant;
    for (int n = 0; n < NL; n++) begin
      hold_data_d[n] = hold_data_q[n];
      hold_len_d[n]  = hold_len_q[n];
      if (done[n]) begin
        if (!hold_valid_q[n] || grant[n]) begin
          hold_valid_d[n] = 1'b1;
          hold_data_d[n]  = done_word[n];
          hold_len_d[n]   = done_len[n];
        end else begin
          err_overflow_d[n] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int n = 0; n < NL; n++) begin
        state_q[n]     <= IDLE;
        cnt_q[n]       <= '0;
        asm_q[n]       <= '0;
        hold_data_q[n] <= '0;
        hold_len_q[n]  <= '0;
      end
      hold_valid_q   <= '0;
      err_overflow_q <= '0;
      err_frame_q    <= '0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_lane_q     <= '0;
      out_len_q      <= '0;
      ptr_q          <= '0;
    end else begin
      for (int n = 0; n < NL; n++) begin
        state_q[n]     <= state_d[n];
        cnt_q[n]       <= cnt_d[n];
        asm_q[n]       <= asm_d[n];
        hold_data_q[n] <= hold_data_d[n];
        hold_len_q[n]  <= hold_len_d[n];
      end
      hold_valid_q   <= hold_valid_d;
      err_overflow_q <= err_overflow_d;
      err_frame_q    <= err_frame_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_lane_q     <= out_lane_d;
      out_len_q      <= out_len_d;
      ptr_q          <= ptr_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_lane     = out_lane_q;
  assign out_len      = out_len_q;
  assign err_overflow = err_overflow_q;
  assign err_frame    = err_frame_q;

endmodule

// File: tb/tb_j_result_collector.sv
// tb/tb_j_result_collector.sv - scoreboard bench for j_result_collector
module tb_j_result_collector;

  logic        clk;
  logic        rst_n;
  logic [3:0]  result, result_en, result_start, result_end;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_lane;
  logic [4:0]  out_len;
  logic [3:0]  err_overflow, err_frame;

  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  l;
    logic [4:0]  n;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  j_result_collector #(.SUBARRAY_HEIGHT(1), .ACC_WIDTH(16)) dut (
    .clk          (clk),
    .reset        (rst_n),
    .result       (result),
    .result_en    (result_en),
    .result_start (result_start),
    .result_end   (result_end),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_lane     (out_lane),
    .out_len      (out_len),
    .err_overflow (err_overflow),
    .err_frame    (err_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every accepted output word is compared against the scoreboard head
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word actual=%h/%0d/%0d expected=none", out_data, out_lane, out_len);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_word", {9'd0, out_data, out_lane, out_len}, {9'd0, e.d, e.l, e.n});
      end
    end
  end

  task automatic cyc(input logic [3:0] r, input logic [3:0] e, input logic [3:0] s, input logic [3:0] d);
    result = r; result_en = e; result_start = s; result_end = d;
    @(posedge clk); #1;
    result = '0; result_en = '0; result_start = '0; result_end = '0;
  endtask

  task automatic send_serial(input int lane, input logic [31:0] val, input int nbits);
    logic [3:0] m;
    m = 4'b0001 << lane;
    for (int b = 0; b < nbits; b++)
      cyc(val[b] ? m : 4'b0, m, (b == 0) ? m : 4'b0, (b == nbits - 1) ? m : 4'b0);
  endtask

  task automatic push(input logic [15:0] d, input logic [1:0] l, input logic [4:0] n);
    exp_t e;
    e.d = d; e.l = l; e.n = n;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d expected=0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b1;
    result = '0; result_en = '0; result_start = '0; result_end = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_fields", {11'd0, out_data, out_lane, out_len}, 32'd0);
    chk("rst_err", {24'd0, err_overflow, err_frame}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Lane 0, -3 as 4 bits; latency of two edges after the end bit
    push(16'hFFFD, 2'd0, 5'd4);
    send_serial(0, 32'hD, 4);
    @(negedge clk);
    chk("lat_early", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("lat_t2", {31'd0, out_valid}, 32'd1);
    wait_drain();

    // All four lanes end +7 (5 bits) together; pointer restarts at lane 0
    pulse_reset();
    for (int k = 0; k < 4; k++) push(16'h0007, 2'(k), 5'd5);
    for (int b = 0; b < 5; b++) begin
      logic [31:0] v;
      v = 32'h7;
      cyc(v[b] ? 4'hF : 4'h0, 4'hF, (b == 0) ? 4'hF : 4'h0, (b == 4) ? 4'hF : 4'h0);
    end
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("burst_valid", {31'd0, out_valid}, 32'd1);
    end
    wait_drain();

    // Lane 2: 1-bit word, then overflow while output is stalled
    push(16'hFFFF, 2'd2, 5'd1);
    send_serial(2, 32'h1, 1);
    wait_drain();
    out_ready = 1'b0;
    push(16'h0003, 2'd2, 5'd3);
    push(16'h0000, 2'd2, 5'd1);
    send_serial(2, 32'h3, 3);
    send_serial(2, 32'h0, 1);
    send_serial(2, 32'h2, 2);
    repeat (2) @(negedge clk);
    chk("ovf_flag", {28'd0, err_overflow}, 32'h4);
    chk("stall_data", {15'd0, out_valid, out_data}, {15'd0, 1'b1, 16'h0003});
    chk("no_frame_yet", {28'd0, err_frame}, 32'h0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain();

    // Lane 1: start mid-word after 3 bits, restarted word -5 in 4 bits
    cyc(4'h2, 4'h2, 4'h2, 4'h0);
    cyc(4'h0, 4'h2, 4'h0, 4'h0);
    cyc(4'h2, 4'h2, 4'h0, 4'h0);
    push(16'hFFFB, 2'd1, 5'd4);
    send_serial(1, 32'hB, 4);
    wait_drain();
    chk("frame_restart", {28'd0, err_frame}, 32'h2);

    // Lane 3: 20-bit word truncated to 16; lane 0 orphan bit without start
    push(16'h0005, 2'd3, 5'd16);
    send_serial(3, 32'h00005, 20);
    cyc(4'h1, 4'h1, 4'h0, 4'h0);
    wait_drain();
    chk("frame_trunc", {28'd0, err_frame}, 32'hB);

    // Reset mid-assembly with a stalled output word
    out_ready = 1'b0;
    send_serial(3, 32'h1, 2);
    repeat (3) @(negedge clk);
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    cyc(4'h1, 4'h1, 4'h1, 4'h0);
    cyc(4'h1, 4'h1, 4'h0, 4'h0);
    rst_n = 1'b0;
    #2;
    chk("rst_async_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_async_err", {24'd0, err_overflow, err_frame}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_quiet", {31'd0, out_valid}, 32'd0);
    push(16'h0006, 2'd0, 5'd4);
    send_serial(0, 32'h6, 4);
    wait_drain();
    chk("final_err", {24'd0, err_overflow, err_frame}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
